// File: rtl/gb_interrupt_ctrl_if.sv
// CPU-side memory bus seen by the interrupt controller.
// The CPU drives address/data/strobe; the controller returns read data.
interface gb_interrupt_ctrl_if;
  logic [15:0] addr_i;
  logic [7:0]  data_i;
  logic        wr_en;
  logic [7:0]  rd_data;
  logic        rd_hit;

  modport master (
    output addr_i, data_i, wr_en,
    input  rd_data, rd_hit
  );

  modport slave (
    input  addr_i, data_i, wr_en,
    output rd_data, rd_hit
  );
endinterface

// File: rtl/gb_interrupt_ctrl.sv
// IF/IE interrupt controller for gb_cpu.
// Latches requests, retires the highest-priority pending bit on clear.
module gb_interrupt_ctrl #(
  parameter int          NUM_IRQ      = 5,
  parameter logic [15:0] IF_ADDR      = 16'hFF0F,
  parameter logic [15:0] IE_ADDR      = 16'hFFFF,
  parameter bit          EDGE_MODE    = 1'b1,
  parameter bit          MASKED_CLEAR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  gb_interrupt_ctrl_if.slave bus,
  input  logic               clear_interrupt_flag,
  output logic [7:0]         reg_IF,
  output logic [7:0]         reg_IE,
  output logic               irq_pending,
  output logic               ack_valid,
  output logic [2:0]         ack_idx
);

  logic [NUM_IRQ-1:0] if_q;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] irq_q;

  logic [NUM_IRQ-1:0] set_v;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] clr;
  logic [2:0]         clr_idx;
  logic               found;
  logic [NUM_IRQ-1:0] if_next;
  logic               if_hit;
  logic               ie_hit;

  assign if_hit = (bus.addr_i == IF_ADDR);
  assign ie_hit = (bus.addr_i == IE_ADDR);

  // Request detect, clear candidate selection and IF next state
  always_comb begin
    set_v   = '0;
    cand    = '0;
    clr     = '0;
    clr_idx = '0;
    found   = 1'b0;
    if_next = if_q;
    if (EDGE_MODE) set_v = irq_i & ~irq_q;
    else           set_v = irq_i;
    if (MASKED_CLEAR) cand = if_q & ie_q[NUM_IRQ-1:0];
    else              cand = if_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!found && cand[i]) begin
        found   = 1'b1;
        clr_idx = 3'(i);
        clr[i]  = clear_interrupt_flag;
      end
    end
    if (bus.wr_en && if_hit) if_next = bus.data_i[NUM_IRQ-1:0];
    if_next = (if_next & ~clr) | set_v;
  end

  // Register state; requests are sampled for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_q      <= '0;
      ie_q      <= '0;
      irq_q     <= '0;
      ack_valid <= 1'b0;
      ack_idx   <= '0;
    end else begin
      if_q      <= if_next;
      irq_q     <= irq_i;
      ack_valid <= |clr;
      if (|clr) ack_idx <= clr_idx;
      if (bus.wr_en && ie_hit) ie_q <= bus.data_i;
    end
  end

  // Register views and bus read mux
  always_comb begin
    reg_IF = '0;
    reg_IF[NUM_IRQ-1:0] = if_q;
    reg_IE = ie_q;
    irq_pending = |(if_q & ie_q[NUM_IRQ-1:0]);
    bus.rd_data = '0;
    bus.rd_hit  = 1'b0;
    if (if_hit) begin
      bus.rd_data = 8'hFF;
      bus.rd_data[NUM_IRQ-1:0] = if_q;
      bus.rd_hit  = 1'b1;
    end else if (ie_hit) begin
      bus.rd_data = ie_q;
      bus.rd_hit  = 1'b1;
    end
  end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Bench for gb_interrupt_ctrl: two configurations driven in lockstep.
// Directed plan steps followed by random traffic against a reference model.
module tb_gb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        wr;
  logic        clr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gb_interrupt_ctrl_if bus0 ();
  gb_interrupt_ctrl_if bus1 ();

  assign bus0.addr_i = addr;
  assign bus0.data_i = data;
  assign bus0.wr_en  = wr;
  assign bus1.addr_i = addr;
  assign bus1.data_i = data;
  assign bus1.wr_en  = wr;

  logic [7:0] if0, ie0, if1, ie1;
  logic       pend0, av0, pend1, av1;
  logic [2:0] ai0, ai1;

  gb_interrupt_ctrl dut0 (
    .clk(clk), .reset(rst), .irq_i(irq), .bus(bus0.slave),
    .clear_interrupt_flag(clr),
    .reg_IF(if0), .reg_IE(ie0), .irq_pending(pend0),
    .ack_valid(av0), .ack_idx(ai0)
  );

  gb_interrupt_ctrl #(
    .EDGE_MODE(1'b0), .MASKED_CLEAR(1'b0)
  ) dut1 (
    .clk(clk), .reset(rst), .irq_i(irq), .bus(bus1.slave),
    .clear_interrupt_flag(clr),
    .reg_IF(if1), .reg_IE(ie1), .irq_pending(pend1),
    .ack_valid(av1), .ack_idx(ai1)
  );

  // Reference model: index 0 = edge/masked, index 1 = level/unmasked
  int unsigned m_if[2];
  int unsigned m_ie[2];
  int unsigned m_q[2];
  int unsigned m_av[2];
  int unsigned m_ai[2];

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      bit edge_m = (k == 0);
      bit mask_m = (k == 0);
      int unsigned cand, setv, nif;
      int ret = -1;
      if (!rst) begin
        m_if[k] = 0; m_ie[k] = 0; m_q[k] = 0;
        m_av[k] = 0; m_ai[k] = 0;
      end else begin
        cand = m_if[k] & (mask_m ? m_ie[k] : 32'hFF) & 32'h1F;
        if (clr)
          for (int b = 0; b < 5; b++)
            if (ret < 0 && ((cand >> b) & 1) == 1) ret = b;
        setv = edge_m ? (irq & ~m_q[k] & 32'h1F) : irq;
        nif = (wr && addr == 16'hFF0F) ? (data & 32'h1F) : m_if[k];
        if (ret >= 0) nif = nif & ~(32'd1 << ret);
        nif = nif | setv;
        if (wr && addr == 16'hFFFF) m_ie[k] = data;
        m_if[k] = nif;
        m_q[k] = irq;
        m_av[k] = (ret >= 0) ? 1 : 0;
        if (ret >= 0) m_ai[k] = ret;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] erd;
    logic       ehit;
    for (int k = 0; k < 2; k++) begin
      erd  = 8'h00;
      ehit = 1'b0;
      if (addr == 16'hFF0F) begin
        erd = 8'hE0 | 8'(m_if[k]); ehit = 1'b1;
      end else if (addr == 16'hFFFF) begin
        erd = 8'(m_ie[k]); ehit = 1'b1;
      end
      if (k == 0) begin
        check("if0", if0, 8'(m_if[0]));
        check("ie0", ie0, 8'(m_ie[0]));
        check("pend0", {7'd0, pend0}, {7'd0, (m_if[0] & m_ie[0] & 32'h1F) != 0});
        check("av0", {7'd0, av0}, 8'(m_av[0]));
        check("ai0", {5'd0, ai0}, 8'(m_ai[0]));
        check("rd0", bus0.rd_data, erd);
        check("hit0", {7'd0, bus0.rd_hit}, {7'd0, ehit});
      end else begin
        check("if1", if1, 8'(m_if[1]));
        check("ie1", ie1, 8'(m_ie[1]));
        check("pend1", {7'd0, pend1}, {7'd0, (m_if[1] & m_ie[1] & 32'h1F) != 0});
        check("av1", {7'd0, av1}, 8'(m_av[1]));
        check("ai1", {5'd0, ai1}, 8'(m_ai[1]));
        check("rd1", bus1.rd_data, erd);
        check("hit1", {7'd0, bus1.rd_hit}, {7'd0, ehit});
      end
    end
  endtask

  task automatic step(input logic r, input logic [4:0] i,
                      input logic [15:0] a, input logic [7:0] d,
                      input logic w, input logic c);
    rst = r; irq = i; addr = a; data = d; wr = w; clr = c;
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  initial begin
    int r;
    logic [15:0] ra;
    // Reset with hostile inputs
    step(0, 5'h1F, 16'hFFFF, 8'hFF, 1, 1);
    step(0, 5'h1F, 16'hFFFF, 8'hFF, 1, 1);
    check("rst_if", if0, 8'h00);
    step(1, 5'h00, 16'hFF0F, 8'h00, 0, 0);
    check("rst_rd", bus0.rd_data, 8'hE0);
    // Held request, IF written to zero in cycle 2
    step(1, 5'h04, 16'hFF0F, 8'h00, 0, 0);
    step(1, 5'h04, 16'hFF0F, 8'h00, 1, 0);
    check("edge_wr", if0, 8'h00);
    check("lvl_wr", if1, 8'h04);
    step(1, 5'h04, 16'hFF0F, 8'h00, 0, 0);
    step(1, 5'h04, 16'hFF0F, 8'h00, 0, 0);
    step(1, 5'h00, 16'h0000, 8'h00, 0, 0);
    // Masked vs unmasked clear
    step(1, 5'h00, 16'hFF0F, 8'h0A, 1, 0);
    step(1, 5'h00, 16'hFFFF, 8'h08, 1, 0);
    step(1, 5'h00, 16'hFF0F, 8'h00, 0, 1);
    check("mclr_if", if0, 8'h02);
    check("uclr_if", if1, 8'h08);
    check("mclr_ai", {5'd0, ai0}, 8'h03);
    check("uclr_ai", {5'd0, ai1}, 8'h01);
    step(1, 5'h00, 16'hFF0F, 8'h00, 0, 0);
    // Clear and rising request on the same bit
    step(1, 5'h00, 16'hFF0F, 8'h01, 1, 0);
    step(1, 5'h00, 16'hFFFF, 8'h01, 1, 0);
    step(1, 5'h01, 16'hFF0F, 8'h00, 0, 1);
    check("race_if", if0, 8'h01);
    step(1, 5'h00, 16'hFF0F, 8'h00, 0, 0);
    // Request beats a same-cycle write
    step(1, 5'h10, 16'hFF0F, 8'h00, 1, 0);
    check("wr_req", if0, 8'h10);
    step(1, 5'h00, 16'hFFFF, 8'h10, 1, 0);
    check("pend_on", {7'd0, pend0}, 8'h01);
    // Clear with nothing enabled, then reset mid-run
    step(1, 5'h00, 16'hFF0F, 8'h04, 1, 0);
    step(1, 5'h00, 16'hFFFF, 8'h00, 1, 0);
    step(1, 5'h00, 16'hFF0F, 8'h00, 0, 1);
    check("noclr_if", if0, 8'h04);
    check("noclr_av", {7'd0, av0}, 8'h00);
    step(1, 5'h00, 16'h1234, 8'h00, 0, 0);
    step(0, 5'h1F, 16'hFF0F, 8'hFF, 1, 1);
    check("mid_rst", if0, 8'h00);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 2));
      ra = (r == 0) ? 16'hFF0F : (r == 1) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(0, 49) != 0,
           5'($urandom),
           ra,
           8'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_interrupt_ctrl.md
Name: gb_interrupt_ctrl

Overview:
Parametrised interrupt controller that owns the IF and IE registers for the gb_cpu core.
- Latches peripheral interrupt requests into IF.
- Exposes IF and IE to the CPU over the memory-mapped bus.
- Services the CPU's clear_interrupt_flag pulse by clearing the highest-priority pending source.
- Generalises the fixed 5-source, unmasked clear logic to N sources, with edge/level request mode, IE-masked clear and an acknowledge report.

Parameters:
NUM_IRQ, 5, number of request sources (1..8); bit 0 is highest priority
IF_ADDR, 16'hFF0F, bus address of IF
IE_ADDR, 16'hFFFF, bus address of IE
EDGE_MODE, 1, 1 = set IF on rising edge of irq_i; 0 = set IF every cycle irq_i is high
MASKED_CLEAR, 1, 1 = clear selects lowest bit of IF&IE; 0 = lowest bit of IF regardless of IE

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
irq_i  in  NUM_IRQ  peripheral request lines
addr_i  in  16  CPU bus address (addr_o of gb_cpu)
data_i  in  8  CPU write data (data_o of gb_cpu)
wr_en  in  1  CPU write strobe (drive_data_bus of gb_cpu)
clear_interrupt_flag  in  1  CPU request to retire one pending interrupt
reg_IF  out  8  IF to CPU; bits >= NUM_IRQ read 0
reg_IE  out  8  IE to CPU, all 8 bits
irq_pending  out  1  combinational |(IF & IE) over the low NUM_IRQ bits
rd_data  out  8  combinational bus read data
rd_hit  out  1  high when addr_i equals IF_ADDR or IE_ADDR
ack_valid  out  1  registered; high for one cycle after a clear that retired a bit
ack_idx  out  3  registered; index of the retired bit

Behaviour:
Reset (reset==0 at clk edge):
- IF, IE, irq_q (previous irq_i sample), ack_valid and ack_idx all become 0.
- Reset overrides every other input that cycle, including writes and requests.

Request detect:
- set[i] = irq_i[i] & ~irq_q[i] when EDGE_MODE=1, else irq_i[i].
- irq_q <= irq_i every non-reset cycle.

Clear select:
- cand = IF & (MASKED_CLEAR ? IE : all-ones), low NUM_IRQ bits only, using the current registered values.
- clr = one-hot of the lowest set bit of cand when clear_interrupt_flag is high; otherwise 0.

IF next-state, in order of increasing precedence:
- base = (wr_en && addr_i==IF_ADDR) ? data_i[NUM_IRQ-1:0] : IF
- base &= ~clr
- IF_next = base | set
- A request always wins over a same-cycle write or clear of the same bit.

IE:
- IE <= data_i when wr_en && addr_i==IE_ADDR.
- IE is unaffected by clears.

Acknowledge:
- Next cycle: ack_valid = |clr; ack_idx = index of clr, else holds its previous value.
- Latency is 1 cycle.
- A clear with cand==0 changes nothing and gives ack_valid=0.

Reads:
- addr_i==IF_ADDR: rd_data = {1s in bits >= NUM_IRQ, IF}. Example: NUM_IRQ=5 gives 8'hE0 | IF.
- addr_i==IE_ADDR: rd_data = IE.
- Any other address: rd_data = 0, rd_hit = 0.
- Reads have no side effects.

Concurrency and width rules:
- Write, clear and request may all occur in one cycle; the precedence above applies.
- IF_ADDR==IE_ADDR is illegal.
- Unused IF bits are never stored.

Test Plan:
1. Hold reset=0 two cycles with irq_i=all-ones and wr_en to IE_ADDR -> IF=0, IE=0, ack_valid=0. Then addr_i=FF0F -> rd_data=8'hE0, rd_hit=1.
2. EDGE_MODE=1: irq_i[2] high for 4 cycles; write IF=0 on cycle 2 -> IF=8'h04 after cycle 1, 8'h00 after the write, and no re-set while held. With EDGE_MODE=0 -> IF returns to 8'h04 the cycle after the write.
3. Write IF=8'h0A, IE=8'h08, pulse clear -> IF=8'h02, next cycle ack_valid=1 and ack_idx=3, irq_pending=0. Same with MASKED_CLEAR=0 -> IF=8'h08, ack_idx=1.
4. IF=8'h01, IE=8'h01; clear and a rising irq_i[0] in the same cycle -> IF stays 8'h01, ack_valid=1, ack_idx=0, irq_pending stays 1.
5. Write IF=8'h00 while irq_i[4] rises -> IF=8'h10. Then IE=8'h10 -> irq_pending=1.
6. IF=8'h04, IE=8'h00, MASKED_CLEAR=1, pulse clear -> IF unchanged at 8'h04, ack_valid=0, ack_idx holds its previous value. Then drive reset=0 mid-sequence -> all state 0 next edge.
